// File: rtl/sn74hc165_reader_pkg.sv
// Shared types and constant helpers for the 74HC165 serial reader.
package sn74hc165_reader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    HIGH   = 3'd3,
    LOW    = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Counters that must hold 0..max_value never collapse to zero width.
  function automatic int width_for(input int max_value);
    return (max_value < 2) ? 1 : clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sn74hc165_reader_if.sv
// Pin-level bundle between the reader (master) and the 74HC165 chip (slave).
interface sn74hc165_reader_if;

  logic SN74HC165_data;
  logic SN74HC165_load_n;
  logic SN74HC165_data_clk;

  modport master (
    input  SN74HC165_data,
    output SN74HC165_load_n,
    output SN74HC165_data_clk
  );

  modport slave (
    output SN74HC165_data,
    input  SN74HC165_load_n,
    input  SN74HC165_data_clk
  );

endinterface

// File: rtl/sn74hc165_reader_key_debounce.sv
// Single-key conditioner fed once per frame; filtering only with SN74HC165_DEBOUNCE_EN.
// The falling-edge output is 'released' because 'release' is a reserved word.
module key_debounce
  import sn74hc165_reader_pkg::*;
`ifdef SN74HC165_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_SCANS = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic press,
  output logic released
);

`ifdef SN74HC165_DEBOUNCE_EN
  localparam int CW = width_for(DEBOUNCE_SCANS - 1);

  logic [CW-1:0] diff_cnt;

  // Any agreeing frame restarts the run of differing frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
      diff_cnt <= '0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      if (sample_en) begin
        if (raw == stable) begin
          diff_cnt <= '0;
        end else if (diff_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
          stable   <= raw;
          press    <= raw;
          released <= ~raw;
          diff_cnt <= '0;
        end else begin
          diff_cnt <= diff_cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      if (sample_en) begin
        stable   <= raw;
        press    <= raw & ~stable;
        released <= ~raw & stable;
      end
    end
  end
`endif

endmodule

// File: rtl/sn74hc165_reader.sv
// Periodic 74HC165 scanner: load, shift N_BITS MSB-first, publish a snapshot and per-key edges.
// Key filtering is enabled by defining SN74HC165_DEBOUNCE_EN.
module sn74hc165_reader
  import sn74hc165_reader_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int CLK_DIV        = 12,
  parameter int SCAN_DIV       = 120000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sn74hc165_reader_if.master   pins,
  output logic [N_BITS-1:0]    o_buf,
  output logic                 o_valid,
  output logic [N_BITS-1:0]    o_stable,
  output logic [N_BITS-1:0]    o_press,
  output logic [N_BITS-1:0]    o_release
);

  localparam int FRAME_LEN = 2 * CLK_DIV * N_BITS + 1;
  localparam int SCAN_MAX  = (SCAN_DIV > FRAME_LEN) ? SCAN_DIV : FRAME_LEN;
  localparam int HW        = width_for(CLK_DIV - 1);
  localparam int BW        = width_for(N_BITS - 1);
  localparam int SW        = width_for(SCAN_MAX);

  if (N_BITS < 2 || N_BITS > 32) begin : g_bad_n_bits
    $error("N_BITS must be within 2..32");
  end
  if (CLK_DIV < 1 || SCAN_DIV < 1 || DEBOUNCE_SCANS < 1) begin : g_bad_div
    $error("CLK_DIV, SCAN_DIV and DEBOUNCE_SCANS must be at least 1");
  end

  state_t            state;
  state_t            state_next;
  logic [HW-1:0]     half_cnt;
  logic [BW-1:0]     bit_idx;
  logic [SW-1:0]     scan_cnt;
  logic [N_BITS-1:0] shreg;
  logic [1:0]        data_sync;
  logic              load_n_q;
  logic              data_clk_q;
  logic              half_last;
  logic              scan_due;
  logic              sample;

  assign half_last = (half_cnt == HW'(CLK_DIV - 1));
  assign scan_due  = (scan_cnt >= SW'(SCAN_DIV - 1));

  assign pins.SN74HC165_load_n   = load_n_q;
  assign pins.SN74HC165_data_clk = data_clk_q;

  // Samples land at the end of SETTLE and of each LOW, when QH has had a full half-period to settle.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE:   if (scan_due) state_next = LOAD;
      LOAD:   if (half_last) state_next = SETTLE;
      SETTLE: if (half_last) begin
                sample     = 1'b1;
                state_next = HIGH;
              end
      HIGH:   if (half_last) state_next = LOW;
      LOW:    if (half_last) begin
                sample     = 1'b1;
                state_next = (bit_idx == BW'(N_BITS - 1)) ? DONE : HIGH;
              end
      DONE:   state_next = scan_due ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin drives are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      half_cnt   <= '0;
      bit_idx    <= '0;
      scan_cnt   <= '0;
      shreg      <= '0;
      data_sync  <= '0;
      load_n_q   <= 1'b1;
      data_clk_q <= 1'b0;
      o_buf      <= '0;
      o_valid    <= 1'b0;
    end else begin
      state      <= state_next;
      data_sync  <= {data_sync[0], pins.SN74HC165_data};
      load_n_q   <= (state != LOAD);
      data_clk_q <= (state == HIGH);
      o_valid    <= (state == DONE);

      if (state_next == LOAD && state != LOAD) begin
        scan_cnt <= '0;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (state_next != state || state == IDLE || state == DONE) begin
        half_cnt <= '0;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end

      if (sample) begin
        shreg <= {shreg[N_BITS-2:0], data_sync[1]};
      end

      if (state == LOAD) begin
        bit_idx <= '0;
      end else if (sample && bit_idx != BW'(N_BITS - 1)) begin
        bit_idx <= bit_idx + 1'b1;
      end

      if (state == DONE) begin
        o_buf <= shreg;
      end
    end
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_key
    key_debounce
`ifdef SN74HC165_DEBOUNCE_EN
      #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS))
`endif
      u_key (
        .clk       (clk),
        .rst       (rst),
        .sample_en (o_valid),
        .raw       (o_buf[i]),
        .stable    (o_stable[i]),
        .press     (o_press[i]),
        .released  (o_release[i])
      );
  end

endmodule

// File: tb/tb_sn74hc165_reader.sv
// Scoreboard bench: behavioural '165 chips on the pins, a frame-history key model, and pin timing monitors.
module tb_sn74hc165_reader;

  localparam int N  = 8;
  localparam int T  = 3;
  localparam int SD = 64;
  localparam int DS = 4;

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] stable;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t         sb[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_stable = '0;

  logic [N-1:0] par  = '0;
  logic [N-1:0] par2 = 8'h3C;
  logic [N-1:0] sr   = '0;
  logic [N-1:0] sr2  = '0;

  logic [N-1:0] o_buf, o_stable, o_press, o_release;
  logic         o_valid;
  logic [N-1:0] o_buf2, o_stable2, o_press2, o_release2;
  logic         o_valid2;

  sn74hc165_reader_if pins();
  sn74hc165_reader_if pins2();

  sn74hc165_reader #(.N_BITS(N), .CLK_DIV(T), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .pins(pins),
    .o_buf(o_buf), .o_valid(o_valid), .o_stable(o_stable),
    .o_press(o_press), .o_release(o_release)
  );

  sn74hc165_reader #(.N_BITS(N), .CLK_DIV(T), .SCAN_DIV(10), .DEBOUNCE_SCANS(DS)) dut2 (
    .clk(clk), .rst(rst), .pins(pins2),
    .o_buf(o_buf2), .o_valid(o_valid2), .o_stable(o_stable2),
    .o_press(o_press2), .o_release(o_release2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Chip behaviour: parallel load while SH/LD is low, shift towards QH on rising CLK otherwise.
  always @(negedge pins.SN74HC165_load_n or posedge pins.SN74HC165_data_clk)
    if (!pins.SN74HC165_load_n) sr <= par;
    else sr <= {sr[N-2:0], 1'b0};
  assign pins.SN74HC165_data = sr[N-1];

  always @(negedge pins2.SN74HC165_load_n or posedge pins2.SN74HC165_data_clk)
    if (!pins2.SN74HC165_load_n) sr2 <= par2;
    else sr2 <= {sr2[N-2:0], 1'b0};
  assign pins2.SN74HC165_data = sr2[N-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_stable = '0;
    hist.delete();
    sb.delete();
  endtask

  // A key changes once its last DS frames all disagree with the accepted state (or on any change without filtering).
  task automatic applyStimulus(input logic [N-1:0] v);
    exp_t e;
    logic acc;
    par = v;
    hist.push_back(v);
    if (hist.size() > DS) void'(hist.pop_front());
    e.raw   = v;
    e.press = '0;
    e.rel   = '0;
    for (int b = 0; b < N; b++) begin
`ifdef SN74HC165_DEBOUNCE_EN
      acc = (hist.size() == DS);
      for (int k = 0; k < hist.size(); k++)
        if (hist[k][b] == m_stable[b]) acc = 1'b0;
`else
      acc = (v[b] != m_stable[b]);
`endif
      if (acc) begin
        e.press[b] = v[b];
        e.rel[b]   = ~v[b];
        m_stable[b] = v[b];
      end
    end
    e.stable = m_stable;
    sb.push_back(e);
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("o_valid timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: snapshot on o_valid, key outputs one cycle later, pulses gone the cycle after.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !o_valid) continue;
      if (sb.size() == 0) begin
        checkOutput("unexpected o_valid", 32'd1, 32'd0);
        continue;
      end
      e = sb.pop_front();
      checkOutput("o_buf", 32'(o_buf), 32'(e.raw));
      @(negedge clk);
      if (rst) continue;
      checkOutput("o_stable", 32'(o_stable), 32'(e.stable));
      checkOutput("o_press", 32'(o_press), 32'(e.press));
      checkOutput("o_release", 32'(o_release), 32'(e.rel));
      @(negedge clk);
      if (rst) continue;
      checkOutput("o_press width", 32'(o_press), 32'd0);
      checkOutput("o_release width", 32'(o_release), 32'd0);
    end
  end

  // Pin timing monitor for the main instance.
  initial begin
    logic prev_ld, prev_dc;
    int   low_len, rises, last_fall;
    bit   first_after_rst;
    prev_ld = 1'b1; prev_dc = 1'b0;
    low_len = 0; rises = 0; last_fall = -1; first_after_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_fall = -1; first_after_rst = 1'b1; low_len = 0; rises = 0;
      end else begin
        if (prev_ld && !pins.SN74HC165_load_n) begin
          if (last_fall >= 0) checkOutput("load_n period", 32'(cyc - last_fall), 32'(SD));
          last_fall = cyc;
          low_len = 0;
          rises = 0;
        end
        if (!pins.SN74HC165_load_n) low_len++;
        if (!prev_dc && pins.SN74HC165_data_clk) rises++;
        if (o_valid) begin
          checkOutput("load_n low cycles", 32'(low_len), 32'(T));
          checkOutput("data_clk rises", 32'(rises), 32'(N - 1));
          if (first_after_rst) checkOutput("first o_valid cycle", 32'(cyc), 32'(2 * T * N + 1));
          first_after_rst = 1'b0;
        end
      end
      prev_ld = pins.SN74HC165_load_n;
      prev_dc = pins.SN74HC165_data_clk;
    end
  end

  // Back-to-back instance: snapshot correct and SH/LD falls right after each o_valid.
  initial begin
    logic prev_ld2;
    int   last_valid2;
    prev_ld2 = 1'b1;
    last_valid2 = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_valid2 = -1;
      end else begin
        if (prev_ld2 && !pins2.SN74HC165_load_n && last_valid2 >= 0)
          checkOutput("b2b load after o_valid", 32'(cyc - last_valid2), 32'd1);
        if (o_valid2) begin
          checkOutput("b2b o_buf", 32'(o_buf2), 32'(par2));
          last_valid2 = cyc;
        end
      end
      prev_ld2 = pins2.SN74HC165_load_n;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global timeout reached at cycle %0d", cyc);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [N-1:0] dir[15];
    logic [N-1:0] cur;
    bit ok;
    int idx;
    dir = '{8'hA5, 8'hA5, 8'hA5, 8'hA4, 8'hA4, 8'hA4, 8'hA4,
            8'hA5, 8'hA5, 8'hA5, 8'hA4, 8'hA5, 8'hA5, 8'hA5, 8'hA5};

    rst = 1'b1;
    modelReset();
    applyStimulus(8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    ok = 1'b1;
    foreach (dir[i]) begin
      waitValid(ok);
      if (!ok) break;
      applyStimulus(dir[i]);
    end

    cur = dir[14];
    for (int f = 0; f < 20 && ok; f++) begin
      waitValid(ok);
      if (!ok) break;
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, N - 1);
        cur[idx] = ~cur[idx];
      end
      applyStimulus(cur);
    end

    // Let the last pushed frame finish, then reset the following frame while data_clk is high.
    if (ok) waitValid(ok);
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!pins.SN74HC165_load_n) begin ok = 1'b1; break; end
      end
      if (ok) begin
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (pins.SN74HC165_data_clk) begin ok = 1'b1; break; end
        end
      end
      if (!ok) checkOutput("frame start timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("reset load_n", 32'(pins.SN74HC165_load_n), 32'd1);
      checkOutput("reset data_clk", 32'(pins.SN74HC165_data_clk), 32'd0);
      checkOutput("reset o_buf", 32'(o_buf), 32'd0);
      checkOutput("reset o_valid", 32'(o_valid), 32'd0);
      checkOutput("reset o_stable", 32'(o_stable), 32'd0);
      modelReset();
      cur = N'($urandom);
      applyStimulus(cur);
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
    end

    for (int f = 0; f < 6 && ok; f++) begin
      waitValid(ok);
      if (!ok) break;
      idx = $urandom_range(0, N - 1);
      cur[idx] = ~cur[idx];
      applyStimulus(cur);
    end
    if (ok) waitValid(ok);
    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
